vga_rect_blitter: RTL and testbench

IO-bus initiator that paints a filled, single-colour rectangle into the video card by issuing the same `X` / `Y` / `PIXEL` register writes the MIPS core would otherwise issue one by one. It takes one rectangle command through a valid/ready handshake. It requests the IO bus from the motherboard arbiter, then streams one write per granted cycle to the video register addresses and pulses `done`. Typical use is clearing paddles and the ball without spending CPU cycles.

---
 rtl/vga_rect_blitter_pkg.sv | 17 +
 rtl/vga_rect_blitter_if.sv | 32 +++
 rtl/vga_rect_blitter.sv | 165 ++++++++++++++++
 tb/tb_vga_rect_blitter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rect_blitter_pkg.sv
// Shared IO constants and blitter state encoding.
// The IO_VGA_* addresses are also used by the motherboard address decoder.
package vga_rect_blitter_pkg;

  localparam logic [3:0] IO_VGA_X     = 4'h0;
  localparam logic [3:0] IO_VGA_Y     = 4'h1;
  localparam logic [3:0] IO_VGA_PIXEL = 4'h2;

  // Blitter FSM state encoding
  typedef logic [2:0] blit_state_t;
  localparam blit_state_t ST_IDLE    = 3'd0;
  localparam blit_state_t ST_SET_Y   = 3'd1;
  localparam blit_state_t ST_SET_X   = 3'd2;
  localparam blit_state_t ST_SET_PIX = 3'd3;
  localparam blit_state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/vga_rect_blitter_if.sv
// Command handshake plus IO-bus initiator signals of the rectangle blitter.
// master: the side issuing commands and granting the bus; slave: the blitter.
interface vga_rect_blitter_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [X_W-1:0] cmd_x;
  logic [Y_W-1:0] cmd_y;
  logic [X_W-1:0] cmd_w;
  logic [Y_W-1:0] cmd_h;
  logic [2:0]     cmd_color;
  logic           bus_req;
  logic           bus_gnt;
  logic           IsIO;
  logic [3:0]     IOAddr;
  logic           IOWriteEn;
  logic [31:0]    IOWriteData;
  logic           busy;
  logic           done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, bus_gnt,
    input  cmd_ready, bus_req, IsIO, IOAddr, IOWriteEn, IOWriteData, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, bus_gnt,
    output cmd_ready, bus_req, IsIO, IOAddr, IOWriteEn, IOWriteData, busy, done
  );
endinterface

// File: rtl/vga_rect_blitter.sv
// Filled-rectangle blitter: accepts one clipped rectangle command and streams
// Y / X / PIXEL register writes to the video card, one per granted bus cycle.
module vga_rect_blitter
  import vga_rect_blitter_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input logic                 CLK,
  input logic                 RST,
  vga_rect_blitter_if.slave   bif
);

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  blit_state_t    state_reg;
  logic [X_W-1:0] x0_reg;
  logic [X_W-1:0] cx_reg;
  logic [Y_W-1:0] cy_reg;
  logic [X_W:0]   x_end_reg;
  logic [Y_W:0]   y_end_reg;
  logic [2:0]     color_reg;
  logic [3:0]     addr_hold_reg;
  logic [31:0]    data_hold_reg;

  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;
  logic [X_W:0]   x_end_next;
  logic [Y_W:0]   y_end_next;
  logic [X_W:0]   cx_inc;
  logic [Y_W:0]   cy_inc;
  logic           empty;
  logic           last_col;
  logic           last_row;
  logic           wr_en;
  logic [3:0]     wr_addr;
  logic [31:0]    wr_data;

  // One extra bit on the adders so x0+w / y0+h never wrap before clipping
  assign x_sum      = {1'b0, bif.cmd_x} + {1'b0, bif.cmd_w};
  assign y_sum      = {1'b0, bif.cmd_y} + {1'b0, bif.cmd_h};
  assign x_end_next = (x_sum > SCR_W) ? SCR_W : x_sum;
  assign y_end_next = (y_sum > SCR_H) ? SCR_H : y_sum;

  assign cx_inc   = {1'b0, cx_reg} + (X_W+1)'(1);
  assign cy_inc   = {1'b0, cy_reg} + (Y_W+1)'(1);
  assign empty    = ({1'b0, cx_reg} >= x_end_reg) || ({1'b0, cy_reg} >= y_end_reg);
  assign last_col = (cx_inc >= x_end_reg);
  assign last_row = (cy_inc >= y_end_reg);

  // Write strobe and payload for the current state; gated by the grant,
  // address/data fall back to the last written values when no write happens
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_hold_reg;
    wr_data = data_hold_reg;
    if (bif.bus_gnt) begin
      case (state_reg)
        ST_SET_Y: begin
          if (!empty) begin
            wr_en   = 1'b1;
            wr_addr = IO_VGA_Y;
            wr_data = 32'(cy_reg);
          end
        end
        ST_SET_X: begin
          wr_en   = 1'b1;
          wr_addr = IO_VGA_X;
          wr_data = 32'(cx_reg);
        end
        ST_SET_PIX: begin
          wr_en   = 1'b1;
          wr_addr = IO_VGA_PIXEL;
          wr_data = 32'(color_reg);
        end
        default: ;
      endcase
    end
  end

  // FSM and pixel counters; the last pixel of the last row goes straight to
  // DONE so completion lands one cycle after the final write
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      x0_reg    <= '0;
      cx_reg    <= '0;
      cy_reg    <= '0;
      x_end_reg <= '0;
      y_end_reg <= '0;
      color_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bif.cmd_valid) begin
            x0_reg    <= bif.cmd_x;
            cx_reg    <= bif.cmd_x;
            cy_reg    <= bif.cmd_y;
            x_end_reg <= x_end_next;
            y_end_reg <= y_end_next;
            color_reg <= bif.cmd_color;
            state_reg <= ST_SET_Y;
          end
        end
        ST_SET_Y: begin
          if (empty) begin
            state_reg <= ST_DONE;
          end else if (bif.bus_gnt) begin
            state_reg <= ST_SET_X;
          end
        end
        ST_SET_X: begin
          if (bif.bus_gnt) begin
            state_reg <= ST_SET_PIX;
          end
        end
        ST_SET_PIX: begin
          if (bif.bus_gnt) begin
            if (!last_col) begin
              cx_reg    <= cx_inc[X_W-1:0];
              state_reg <= ST_SET_X;
            end else if (last_row) begin
              state_reg <= ST_DONE;
            end else begin
              cx_reg    <= x0_reg;
              cy_reg    <= cy_inc[Y_W-1:0];
              state_reg <= ST_SET_Y;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Remember the last issued address/data so the bus holds them between writes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
    end else if (wr_en) begin
      addr_hold_reg <= wr_addr;
      data_hold_reg <= wr_data;
    end
  end

  assign bif.cmd_ready   = (state_reg == ST_IDLE);
  assign bif.busy        = (state_reg != ST_IDLE);
  assign bif.done        = (state_reg == ST_DONE);
  assign bif.bus_req     = (state_reg == ST_SET_Y) || (state_reg == ST_SET_X) ||
                           (state_reg == ST_SET_PIX);
  assign bif.IsIO        = wr_en;
  assign bif.IOWriteEn   = wr_en;
  assign bif.IOAddr      = wr_addr;
  assign bif.IOWriteData = wr_data;

endmodule

// File: tb/tb_vga_rect_blitter.sv
// Self-checking bench for vga_rect_blitter: directed cases plus random
// rectangles with random grant patterns, checked against a write-list model.
module tb_vga_rect_blitter;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  logic CLK = 1'b0;
  logic RST;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [3:0]  last_addr;
  logic [31:0] last_data;
  int dk;

  vga_rect_blitter_if #(.X_W(X_W), .Y_W(Y_W)) vif();

  vga_rect_blitter #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bif (vif)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cmd_ready"}, vif.cmd_ready, 1);
    chk({pfx, "_bus_req"},   vif.bus_req, 0);
    chk({pfx, "_IsIO"},      vif.IsIO, 0);
    chk({pfx, "_IOWriteEn"}, vif.IOWriteEn, 0);
    chk({pfx, "_IOAddr"},    vif.IOAddr, 0);
    chk({pfx, "_IOWrData"},  vif.IOWriteData, 0);
    chk({pfx, "_busy"},      vif.busy, 0);
    chk({pfx, "_done"},      vif.done, 0);
  endtask

  // Idle cycles: block must stay ready with no writes regardless of grant
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1 vif.bus_gnt = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("idle_ready", vif.cmd_ready, 1);
      chk("idle_wen",   vif.IOWriteEn, 0);
      chk("idle_done",  vif.done, 0);
      chk("idle_addr",  vif.IOAddr, last_addr);
    end
  endtask

  // mode: 0 grant always, 1 random grant, 2 grant never, 3 stall 3 cycles after 2nd write
  task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                         input int mode, input bit hold, input bit chained,
                         input int abort_k, output int done_k);
    logic [35:0] q[$];
    logic [35:0] e;
    logic [X_W-1:0] xv;
    logic [Y_W-1:0] yv;
    logic [X_W-1:0] wv;
    logic [Y_W-1:0] hv;
    logic [2:0] cv;
    int xe, ye, n, left, last_k, stalls, wr_seen, wait_n;
    bit g, exp_wr, exp_done, got_done;
    done_k = -1;
    got_done = 0;
    // reference write list: Y once per row, then X/PIXEL per visible column
    xe = (x + w < SCREEN_W) ? x + w : SCREEN_W;
    ye = (y + h < SCREEN_H) ? y + h : SCREEN_H;
    for (int yy = y; yy < ye; yy++) begin
      if (x < xe) begin
        q.push_back({4'h1, 32'(yy)});
        for (int xx = x; xx < xe; xx++) begin
          q.push_back({4'h0, 32'(xx)});
          q.push_back({4'h2, 32'(c)});
        end
      end
    end
    n = q.size();
    left = n; last_k = 0; stalls = 0; wr_seen = 0;
    xv = x[X_W-1:0]; yv = y[Y_W-1:0]; wv = w[X_W-1:0]; hv = h[Y_W-1:0]; cv = c[2:0];
    vif.cmd_x = xv; vif.cmd_y = yv; vif.cmd_w = wv; vif.cmd_h = hv; vif.cmd_color = cv;
    vif.cmd_valid = 1'b1;
    wait_n = 0;
    while (vif.cmd_ready !== 1'b1 && wait_n < 50) begin
      @(posedge CLK);
      @(negedge CLK);
      wait_n++;
    end
    chk("ready_before_accept", vif.cmd_ready, 1);
    if (chained) chk("b2b_accept_wait", wait_n, 1);
    @(posedge CLK);
    #1;
    if (!hold) vif.cmd_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      case (mode)
        0: g = 1'b1;
        1: g = ($urandom_range(0, 3) != 0);
        2: g = 1'b0;
        default: g = !(wr_seen == 2 && stalls < 3);
      endcase
      vif.bus_gnt = g;
      @(negedge CLK);
      exp_wr   = g && (left > 0);
      exp_done = (n == 0) ? (k == 2) : (left == 0 && k == last_k + 1);
      chk("IOWriteEn", vif.IOWriteEn, exp_wr);
      chk("IsIO",      vif.IsIO, exp_wr);
      chk("done",      vif.done, exp_done);
      chk("busy",      vif.busy, 1);
      chk("ready_low", vif.cmd_ready, 0);
      chk("bus_req",   vif.bus_req, !exp_done);
      if (exp_wr) begin
        e = q.pop_front();
        chk("IOAddr",      vif.IOAddr, e[35:32]);
        chk("IOWriteData", vif.IOWriteData, e[31:0]);
        last_addr = e[35:32];
        last_data = e[31:0];
        left--;
        wr_seen++;
        if (left == 0) last_k = k;
      end else begin
        chk("addr_hold", vif.IOAddr, last_addr);
        chk("data_hold", vif.IOWriteData, last_data);
        if (!g && left > 0) stalls++;
      end
      if (k == abort_k) begin
        // asynchronous reset in mid-cycle, before the write is sampled
        RST = 1'b0;
        vif.cmd_valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("abort");
        RST = 1'b1;
        last_addr = '0;
        last_data = '0;
        @(negedge CLK);
        chk("abort_no_done", vif.done, 0);
        chk("abort_ready",   vif.cmd_ready, 1);
        $display("cmd x=%0d y=%0d w=%0d h=%0d aborted at cycle %0d", x, y, w, h, k);
        return;
      end
      if (exp_done) begin
        done_k = k;
        got_done = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    chk("done_seen", got_done, 1);
    $display("cmd x=%0d y=%0d w=%0d h=%0d c=%0d mode=%0d writes=%0d done_cycle=%0d",
             x, y, w, h, c, mode, n, done_k);
  endtask

  initial begin
    RST = 1'b0;
    vif.cmd_valid = 1'b0;
    vif.bus_gnt = 1'b0;
    vif.cmd_x = '0; vif.cmd_y = '0; vif.cmd_w = '0; vif.cmd_h = '0; vif.cmd_color = '0;
    last_addr = '0;
    last_data = '0;
    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    RST = 1'b1;
    idle(2);

    // basic 2x1 rectangle
    run_cmd(3, 5, 2, 1, 3'b101, 0, 1'b0, 1'b0, 0, dk);
    chk("t1_done_cycle", dk, 6);
    idle(1);

    // empty command, grant never given
    run_cmd(10, 10, 0, 4, 3'b111, 2, 1'b0, 1'b0, 0, dk);
    chk("t2_done_cycle", dk, 2);
    idle(1);

    // clipped at right and bottom edges without wrap
    run_cmd(158, 119, 4, 3, 3'b010, 0, 1'b0, 1'b0, 0, dk);
    chk("t3_done_cycle", dk, 6);
    idle(1);

    // fully off-screen origin
    run_cmd(200, 5, 20, 2, 3'b001, 0, 1'b0, 1'b0, 0, dk);
    chk("t3b_done_cycle", dk, 2);
    idle(1);

    // 2x2 with a 3-cycle grant stall after the 2nd write
    run_cmd(20, 30, 2, 2, 3'b110, 3, 1'b0, 1'b0, 0, dk);
    chk("t4_done_cycle", dk, 14);
    idle(1);

    // reset during the 3rd write of a 4x4, then a fresh command
    run_cmd(40, 40, 4, 4, 3'b011, 0, 1'b0, 1'b0, 3, dk);
    run_cmd(1, 2, 1, 1, 3'b100, 0, 1'b0, 1'b0, 0, dk);
    chk("t5_after_reset_done", dk, 4);
    idle(1);

    // back-to-back with cmd_valid held high
    run_cmd(10, 20, 2, 2, 3'b011, 0, 1'b1, 1'b0, 0, dk);
    chk("t6a_done_cycle", dk, 11);
    run_cmd(50, 60, 1, 1, 3'b110, 0, 1'b0, 1'b1, 0, dk);
    chk("t6b_done_cycle", dk, 4);
    idle(1);

    // random rectangles, some near the screen edges, random grant
    for (int i = 0; i < 25; i++) begin
      int rx, ry;
      rx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 150));
      ry = ($urandom_range(0, 1) != 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 110));
      run_cmd(rx, ry, int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 1'b0, 1'b0, 0, dk);
      idle(1 + int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
